// File: rtl/ram_host_port.sv
`default_nettype none
// ============================================================================
//  Module   : ram_host_port
//  Purpose  : Host-side front end for one port of a synchronous dual-port RAM.
//             Turns a req/ack byte-addressed bus with byte enables into RAM
//             word accesses. Partial writes are read-modify-write; read data
//             is returned registered and out-of-range words are flagged.
//  Revision : 1.0  initial release
// ============================================================================
module ram_host_port #(
   parameter int DAT_WIDTH = 32,
   parameter int ADR_WIDTH = 32,
   parameter int MEM_SIZE  = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_i,
   input  logic                   we_i,
   input  logic [ADR_WIDTH-1:0]   adr_i,
   input  logic [DAT_WIDTH/8-1:0] be_i,
   input  logic [DAT_WIDTH-1:0]   wdat_i,
   output logic                   ack_o,
   output logic                   resp_o,
   output logic [DAT_WIDTH-1:0]   rdat_o,
   output logic                   err_o,
   output logic [ADR_WIDTH-1:0]   ram_adr_o,
   output logic                   ram_we_o,
   output logic [DAT_WIDTH-1:0]   ram_dat_o,
   input  logic [DAT_WIDTH-1:0]   ram_dat_i
);

   localparam int c_BYTES = DAT_WIDTH / 8;
   localparam int c_LSB   = (c_BYTES > 1) ? $clog2(c_BYTES) : 0;

   localparam logic [1:0] c_IDLE      = 2'd0;
   localparam logic [1:0] c_RD_WAIT   = 2'd1;
   localparam logic [1:0] c_RMW_MERGE = 2'd2;

   logic [1:0]           r_state;
   logic [ADR_WIDTH-1:0] r_word;
   logic [c_BYTES-1:0]   r_be;
   logic [DAT_WIDTH-1:0] r_wdat;
   logic                 r_we;
   logic                 r_oor;
   logic                 r_resp;
   logic                 r_err;
   logic [DAT_WIDTH-1:0] r_rdat;

   logic [ADR_WIDTH-1:0] w_word;
   logic                 w_oor;
   logic                 w_be_full;
   logic                 w_be_zero;
   logic                 w_idle;
   logic [DAT_WIDTH-1:0] w_merge;

   // Host byte address to RAM word index, plus range and byte-enable decode
   always_comb begin
      w_word    = adr_i >> c_LSB;
      w_oor     = (w_word >= ADR_WIDTH'(MEM_SIZE));
      w_be_full = &be_i;
      w_be_zero = ~|be_i;
      w_idle    = (r_state == c_IDLE);
   end

   // Byte-wise merge of held write data over the word just read back
   generate
      for (genvar k = 0; k < c_BYTES; k++) begin : g_byte
         assign w_merge[8*k +: 8] = r_be[k] ? r_wdat[8*k +: 8] : ram_dat_i[8*k +: 8];
      end
   endgenerate

   // Acceptance and RAM drive; the RAM sees the live address only while idle
   always_comb begin
      ack_o     = rst_n & req_i & w_idle;
      ram_adr_o = w_idle ? w_word : r_word;
      ram_dat_o = (r_state == c_RMW_MERGE) ? w_merge : wdat_i;
      ram_we_o  = rst_n & ((ack_o & we_i & w_be_full & ~w_oor) |
                           ((r_state == c_RMW_MERGE) & r_we & ~r_oor));
   end

   // Request capture, state sequencing and registered responses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
         r_word  <= '0;
         r_be    <= '0;
         r_wdat  <= '0;
         r_we    <= 1'b0;
         r_oor   <= 1'b0;
         r_resp  <= 1'b0;
         r_err   <= 1'b0;
         r_rdat  <= '0;
      end else begin
         r_resp <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (ack_o) begin
                  r_word <= w_word;
                  r_be   <= be_i;
                  r_wdat <= wdat_i;
                  r_we   <= we_i;
                  r_oor  <= w_oor;
                  if (!we_i) begin
                     r_state <= c_RD_WAIT;
                  end else if (!w_be_full && !w_be_zero) begin
                     // out-of-range partial writes still take the RMW slot
                     // so their response latency matches in-range ones
                     r_state <= c_RMW_MERGE;
                  end else begin
                     r_resp <= 1'b1;
                     r_err  <= w_oor;
                  end
               end
            end
            c_RD_WAIT: begin
               r_rdat  <= r_oor ? '0 : ram_dat_i;
               r_resp  <= 1'b1;
               r_err   <= r_oor;
               r_state <= c_IDLE;
            end
            c_RMW_MERGE: begin
               r_resp  <= 1'b1;
               r_err   <= r_oor;
               r_state <= c_IDLE;
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign resp_o = r_resp;
   assign err_o  = r_err;
   assign rdat_o = r_rdat;

endmodule
`default_nettype wire
